// File: rtl/map_table_nway.sv
// map_table_nway: N-way superscalar register map table.
// Renames up to DISPATCH_W instructions per cycle with intra-bundle bypass,
// absorbs CDB_W completion and RETIRE_W retire broadcasts, and with
// MAP_TABLE_CKPT_EN defined keeps a circular FIFO of NUM_CKPT branch
// checkpoints for single-cycle misprediction recovery.
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   disp_valid/dest/rs*     rename lanes, lane 0 oldest
//   rs1_*/rs2_*             combinational source mappings per lane
//   cdb_valid/cdb_tag       completion broadcasts
//   retire_valid/retire_tag retiring ROB entries
//   ckpt_req/ckpt_release   allocate newest / free oldest checkpoint
//   ckpt_id/ckpt_full       slot allocated on a request / no free slot
//   squash/squash_id        restore the map from a checkpoint
module map_table_nway #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned TAG_W         = 5,
  parameter int unsigned DISPATCH_W    = 2,
  parameter int unsigned CDB_W         = 2,
  parameter int unsigned RETIRE_W      = 2,
  parameter int unsigned NUM_CKPT      = 4,
  localparam int unsigned RW           = $clog2(NUM_ARCH_REGS),
  localparam int unsigned CW           = $clog2(NUM_CKPT)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DISPATCH_W-1:0]       disp_valid,
  input  logic [DISPATCH_W*RW-1:0]    disp_dest_idx,
  input  logic [DISPATCH_W*TAG_W-1:0] disp_dest_tag,
  input  logic [DISPATCH_W*RW-1:0]    disp_rs1_idx,
  input  logic [DISPATCH_W*RW-1:0]    disp_rs2_idx,
  output logic [DISPATCH_W*TAG_W-1:0] rs1_tag,
  output logic [DISPATCH_W*TAG_W-1:0] rs2_tag,
  output logic [DISPATCH_W-1:0]       rs1_valid,
  output logic [DISPATCH_W-1:0]       rs2_valid,
  output logic [DISPATCH_W-1:0]       rs1_ready,
  output logic [DISPATCH_W-1:0]       rs2_ready,
  input  logic [CDB_W-1:0]            cdb_valid,
  input  logic [CDB_W*TAG_W-1:0]      cdb_tag,
  input  logic [RETIRE_W-1:0]         retire_valid,
  input  logic [RETIRE_W*TAG_W-1:0]   retire_tag,
  input  logic                        ckpt_req,
  output logic [CW-1:0]               ckpt_id,
  output logic                        ckpt_full,
  input  logic                        ckpt_release,
  input  logic                        squash,
  input  logic [CW-1:0]               squash_id
);

  logic [NUM_ARCH_REGS-1:0][TAG_W-1:0] tag_q, nxt_tag;
  logic [NUM_ARCH_REGS-1:0]            valid_q, ready_q, nxt_valid, nxt_ready;

  // Any active CDB channel carrying tag t
  function automatic logic cdb_hit(input logic [TAG_W-1:0] t, input logic [CDB_W-1:0] v,
                                   input logic [CDB_W*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_W; c++)
      if (v[c] && tags[c*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  // Any active retire channel carrying tag t
  function automatic logic ret_hit(input logic [TAG_W-1:0] t, input logic [RETIRE_W-1:0] v,
                                   input logic [RETIRE_W*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < RETIRE_W; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  // Source lookup for one lane: youngest older lane writing r wins, else stored entry
  function automatic logic [TAG_W+1:0] lookup(input int lane, input logic [RW-1:0] r);
    logic [TAG_W+1:0] res;
    res = '0;
    if (r != '0) begin
      if (valid_q[r])
        res = {tag_q[r], 1'b1, ready_q[r] | cdb_hit(tag_q[r], cdb_valid, cdb_tag)};
      for (int i = 0; i < DISPATCH_W; i++)
        if (i < lane && disp_valid[i] && disp_dest_idx[i*RW +: RW] == r)
          res = {disp_dest_tag[i*TAG_W +: TAG_W], 2'b10};
    end
    return res;
  endfunction

  // Rename read ports
  always_comb begin
    rs1_tag   = '0;
    rs2_tag   = '0;
    rs1_valid = '0;
    rs2_valid = '0;
    rs1_ready = '0;
    rs2_ready = '0;
    for (int j = 0; j < DISPATCH_W; j++) begin
      {rs1_tag[j*TAG_W +: TAG_W], rs1_valid[j], rs1_ready[j]} = lookup(j, disp_rs1_idx[j*RW +: RW]);
      {rs2_tag[j*TAG_W +: TAG_W], rs2_valid[j], rs2_ready[j]} = lookup(j, disp_rs2_idx[j*RW +: RW]);
    end
  end

  // Post-update map: CDB, then retire over it, then dispatch (highest lane last)
  always_comb begin
    nxt_tag   = tag_q;
    nxt_valid = valid_q;
    nxt_ready = ready_q;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      if (valid_q[r] && cdb_hit(tag_q[r], cdb_valid, cdb_tag)) nxt_ready[r] = 1'b1;
      if (valid_q[r] && ret_hit(tag_q[r], retire_valid, retire_tag)) begin
        nxt_valid[r] = 1'b0;
        nxt_ready[r] = 1'b0;
      end
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (disp_valid[i] && disp_dest_idx[i*RW +: RW] != '0) begin
        nxt_tag[disp_dest_idx[i*RW +: RW]]   = disp_dest_tag[i*TAG_W +: TAG_W];
        nxt_valid[disp_dest_idx[i*RW +: RW]] = 1'b1;
        nxt_ready[disp_dest_idx[i*RW +: RW]] = 1'b0;
      end
    end
  end

`ifdef MAP_TABLE_CKPT_EN
  logic [NUM_ARCH_REGS-1:0][TAG_W-1:0] ck_tag [NUM_CKPT];
  logic [NUM_ARCH_REGS-1:0]            ck_valid [NUM_CKPT];
  logic [NUM_ARCH_REGS-1:0]            ck_ready [NUM_CKPT];
  logic [NUM_ARCH_REGS-1:0]            ck_nxt_valid [NUM_CKPT];
  logic [NUM_ARCH_REGS-1:0]            ck_nxt_ready [NUM_CKPT];
  logic [CW-1:0]                       head_q, tail_q, head_d, tail_d;
  logic [CW:0]                         count_q, count_d;
  logic                                full_q, push;

  // Checkpoints track completions and retirements like the live map
  always_comb begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      ck_nxt_valid[s] = ck_valid[s];
      ck_nxt_ready[s] = ck_ready[s];
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        if (ck_valid[s][r] && cdb_hit(ck_tag[s][r], cdb_valid, cdb_tag)) ck_nxt_ready[s][r] = 1'b1;
        if (ck_valid[s][r] && ret_hit(ck_tag[s][r], retire_valid, retire_tag)) begin
          ck_nxt_valid[s][r] = 1'b0;
          ck_nxt_ready[s][r] = 1'b0;
        end
      end
    end
  end

  // FIFO pointers; a squash truncates the FIFO just before squash_id
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push    = 1'b0;
    if (squash) begin
      tail_d  = squash_id;
      count_d = (CW+1)'(CW'(squash_id - head_q));
      if (ckpt_release && count_d != '0) begin
        head_d  = head_q + CW'(1);
        count_d = count_d - (CW+1)'(1);
      end
    end else begin
      push = ckpt_req && !full_q;
      if (push) begin
        tail_d  = tail_q + CW'(1);
        count_d = count_d + (CW+1)'(1);
      end
      if (ckpt_release && count_q != '0) begin
        head_d  = head_q + CW'(1);
        count_d = count_d - (CW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= (count_d == (CW+1)'(NUM_CKPT));
    end
  end

  // Slot storage; dead slots are simply overwritten on allocation
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_CKPT; s++) begin
      if (push && tail_q == CW'(s)) begin
        ck_tag[s]   <= nxt_tag;
        ck_valid[s] <= nxt_valid;
        ck_ready[s] <= nxt_ready;
      end else begin
        ck_valid[s] <= ck_nxt_valid[s];
        ck_ready[s] <= ck_nxt_ready[s];
      end
    end
  end

  assign ckpt_id   = tail_q;
  assign ckpt_full = full_q;
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_req, ckpt_release, squash_id};
  assign ckpt_id     = '0;
  assign ckpt_full   = 1'b1;
`endif

  // Map state
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q   <= '0;
      valid_q <= '0;
      ready_q <= '0;
    end else if (squash) begin
`ifdef MAP_TABLE_CKPT_EN
      tag_q   <= ck_tag[squash_id];
      valid_q <= ck_nxt_valid[squash_id];
      ready_q <= ck_nxt_ready[squash_id];
`else
      valid_q <= '0;
      ready_q <= '0;
`endif
    end else begin
      tag_q   <= nxt_tag;
      valid_q <= nxt_valid;
      ready_q <= nxt_ready;
    end
  end

endmodule

// File: tb/tb_map_table_nway.sv
module tb_map_table_nway;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] disp_valid;
  logic [9:0] disp_dest_idx, disp_dest_tag, disp_rs1_idx, disp_rs2_idx;
  logic [9:0] rs1_tag, rs2_tag;
  logic [1:0] rs1_valid, rs2_valid, rs1_ready, rs2_ready;
  logic [1:0] cdb_valid, retire_valid;
  logic [9:0] cdb_tag, retire_tag;
  logic       ckpt_req, ckpt_full, ckpt_release, squash;
  logic [1:0] ckpt_id, squash_id;

  int n_tests;
  int n_fail;

  localparam logic [6:0] Z = 7'd0;

  map_table_nway dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_dest_idx(disp_dest_idx), .disp_dest_tag(disp_dest_tag),
    .disp_rs1_idx(disp_rs1_idx), .disp_rs2_idx(disp_rs2_idx),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .retire_valid(retire_valid), .retire_tag(retire_tag),
    .ckpt_req(ckpt_req), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
    .squash(squash), .squash_id(squash_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [1:0] dv;
    logic [4:0] d0, t0, d1, t1;
    logic [4:0] a0, a1, b0, b1;
    logic [1:0] cv;
    logic [4:0] c0, c1;
    logic [1:0] rv;
    logic [4:0] q0, q1;
    logic [6:0] e_a0, e_a1, e_b0, e_b1;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [6:0] ex(input logic [4:0] t, input logic v, input logic r);
    return {t, v, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Source mapping check; tag is don't-care when the expected mapping is invalid
  task automatic chk_rs(input string name, input int lane, input int src, input logic [6:0] e);
    logic [6:0] a;
    if (src == 1) a = {rs1_tag[lane*5 +: 5], rs1_valid[lane], rs1_ready[lane]};
    else          a = {rs2_tag[lane*5 +: 5], rs2_valid[lane], rs2_ready[lane]};
    if (e[1]) chk($sformatf("%s.rs%0d_l%0d", name, src, lane), 32'(a), 32'(e));
    else      chk($sformatf("%s.rs%0d_l%0d", name, src, lane), 32'(a[1:0]), 32'(e[1:0]));
  endtask

  task automatic idle();
    disp_valid = '0; disp_dest_idx = '0; disp_dest_tag = '0;
    disp_rs1_idx = '0; disp_rs2_idx = '0;
    cdb_valid = '0; cdb_tag = '0; retire_valid = '0; retire_tag = '0;
    ckpt_req = 1'b0; ckpt_release = 1'b0; squash = 1'b0; squash_id = '0;
  endtask

  task automatic begin_cycle();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic set_lane(input int lane, input logic v, input logic [4:0] dest,
                          input logic [4:0] tag, input logic [4:0] r1, input logic [4:0] r2);
    disp_valid[lane]           = v;
    disp_dest_idx[lane*5 +: 5] = dest;
    disp_dest_tag[lane*5 +: 5] = tag;
    disp_rs1_idx[lane*5 +: 5]  = r1;
    disp_rs2_idx[lane*5 +: 5]  = r2;
  endtask

  task automatic chk_ckpt(input string name, input logic [1:0] id, input logic full);
    chk({name, ".ckpt_id"}, 32'(ckpt_id), 32'(id));
    chk({name, ".ckpt_full"}, 32'(ckpt_full), 32'(full));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
`ifdef MAP_TABLE_CKPT_EN
    chk_ckpt("reset", 2'd0, 1'b0);
`else
    chk_ckpt("reset", 2'd0, 1'b1);
`endif

    //          name          dv     d0    t0    d1    t1     a0    a1    b0    b1     cv    c0     c1     rv    q0     q1     e_a0             e_a1             e_b0             e_b1
    vecs[0]  = '{"reset_r5",  2'b00, 5'd0, 5'd0, 5'd0, 5'd0,  5'd5, 5'd5, 5'd5, 5'd0,  2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0,  Z,               Z,               Z,               Z};
    vecs[1]  = '{"bypass",    2'b01, 5'd3, 5'd7, 5'd0, 5'd0,  5'd3, 5'd3, 5'd0, 5'd5,  2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0,  Z,               ex(7,1'b1,1'b0), Z,               Z};
    vecs[2]  = '{"stored",    2'b01, 5'd4, 5'd9, 5'd0, 5'd0,  5'd3, 5'd4, 5'd4, 5'd3,  2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0,  ex(7,1'b1,1'b0), ex(9,1'b1,1'b0), Z,               ex(7,1'b1,1'b0)};
    vecs[3]  = '{"cdb_fwd",   2'b00, 5'd0, 5'd0, 5'd0, 5'd0,  5'd4, 5'd3, 5'd0, 5'd4,  2'b01, 5'd9, 5'd0,  2'b00, 5'd0, 5'd0,  ex(9,1'b1,1'b1), ex(7,1'b1,1'b0), Z,               ex(9,1'b1,1'b1)};
    vecs[4]  = '{"retire",    2'b00, 5'd0, 5'd0, 5'd0, 5'd0,  5'd4, 5'd3, 5'd4, 5'd5,  2'b00, 5'd0, 5'd0,  2'b01, 5'd9, 5'd0,  ex(9,1'b1,1'b1), ex(7,1'b1,1'b0), ex(9,1'b1,1'b1), Z};
    vecs[5]  = '{"waw",       2'b11, 5'd6, 5'd2, 5'd6, 5'd3,  5'd4, 5'd6, 5'd6, 5'd3,  2'b01, 5'd2, 5'd0,  2'b00, 5'd0, 5'd0,  Z,               ex(2,1'b1,1'b0), Z,               ex(7,1'b1,1'b0)};
    vecs[6]  = '{"waw_check", 2'b00, 5'd0, 5'd0, 5'd0, 5'd0,  5'd6, 5'd3, 5'd6, 5'd4,  2'b10, 5'd0, 5'd9,  2'b00, 5'd0, 5'd0,  ex(3,1'b1,1'b0), ex(7,1'b1,1'b0), ex(3,1'b1,1'b0), Z};
    vecs[7]  = '{"disp_cdb",  2'b10, 5'd0, 5'd0, 5'd6, 5'd10, 5'd6, 5'd3, 5'd6, 5'd6,  2'b10, 5'd0, 5'd3,  2'b00, 5'd0, 5'd0,  ex(3,1'b1,1'b1), ex(7,1'b1,1'b0), ex(3,1'b1,1'b1), ex(3,1'b1,1'b1)};
    vecs[8]  = '{"disp_ret",  2'b01, 5'd3, 5'd11,5'd0, 5'd0,  5'd6, 5'd3, 5'd3, 5'd6,  2'b00, 5'd0, 5'd0,  2'b01, 5'd7, 5'd0,  ex(10,1'b1,1'b0),ex(11,1'b1,1'b0),ex(7,1'b1,1'b0), ex(10,1'b1,1'b0)};
    vecs[9]  = '{"r0_ignore", 2'b01, 5'd0, 5'd5, 5'd0, 5'd0,  5'd3, 5'd0, 5'd6, 5'd0,  2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0,  ex(11,1'b1,1'b0),Z,               ex(10,1'b1,1'b0),Z};
    vecs[10] = '{"ret_cdb",   2'b00, 5'd5, 5'd12,5'd0, 5'd0,  5'd3, 5'd5, 5'd6, 5'd0,  2'b01, 5'd10,5'd0,  2'b10, 5'd0, 5'd10, ex(11,1'b1,1'b0),Z,               ex(10,1'b1,1'b1),Z};
    vecs[11] = '{"post",      2'b00, 5'd0, 5'd0, 5'd0, 5'd0,  5'd6, 5'd5, 5'd3, 5'd4,  2'b00, 5'd0, 5'd0,  2'b00, 5'd0, 5'd0,  Z,               Z,               ex(11,1'b1,1'b0),Z};

    for (int k = 0; k < 12; k++) begin
      begin_cycle();
      disp_valid    = vecs[k].dv;
      disp_dest_idx = {vecs[k].d1, vecs[k].d0};
      disp_dest_tag = {vecs[k].t1, vecs[k].t0};
      disp_rs1_idx  = {vecs[k].a1, vecs[k].a0};
      disp_rs2_idx  = {vecs[k].b1, vecs[k].b0};
      cdb_valid     = vecs[k].cv;
      cdb_tag       = {vecs[k].c1, vecs[k].c0};
      retire_valid  = vecs[k].rv;
      retire_tag    = {vecs[k].q1, vecs[k].q0};
      @(negedge clock);
      chk_rs(vecs[k].name, 0, 1, vecs[k].e_a0);
      chk_rs(vecs[k].name, 1, 1, vecs[k].e_a1);
      chk_rs(vecs[k].name, 0, 2, vecs[k].e_b0);
      chk_rs(vecs[k].name, 1, 2, vecs[k].e_b1);
    end

`ifdef MAP_TABLE_CKPT_EN
    // Snapshot r1->4, remap to 5, complete 4 inside the checkpoint, squash back
    begin_cycle();
    set_lane(0, 1'b1, 5'd1, 5'd4, 5'd0, 5'd0);
    ckpt_req = 1'b1;
    @(negedge clock);
    chk_ckpt("ck_alloc0", 2'd0, 1'b0);

    begin_cycle();
    set_lane(0, 1'b1, 5'd1, 5'd5, 5'd1, 5'd0);
    @(negedge clock);
    chk_rs("ck_r1_t4", 0, 1, ex(4,1'b1,1'b0));

    begin_cycle();
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd0);
    cdb_valid = 2'b01; cdb_tag = 10'(5'd4);
    @(negedge clock);
    chk_rs("ck_r1_t5", 0, 1, ex(5,1'b1,1'b0));

    begin_cycle();
    squash = 1'b1; squash_id = 2'd0; ckpt_req = 1'b1;
    set_lane(0, 1'b1, 5'd2, 5'd8, 5'd0, 5'd0);
    @(negedge clock);
    chk_ckpt("ck_presquash", 2'd1, 1'b0);

    begin_cycle();
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd3);
    set_lane(1, 1'b0, 5'd0, 5'd0, 5'd2, 5'd0);
    @(negedge clock);
    chk_rs("ck_restore_r1", 0, 1, ex(4,1'b1,1'b1));
    chk_rs("ck_restore_r3", 0, 2, ex(11,1'b1,1'b0));
    chk_rs("ck_restore_r2", 1, 1, Z);
    chk_ckpt("ck_after_squash", 2'd0, 1'b0);

    // Fill all slots, overflow, then release/request interplay with wrap
    for (int k = 0; k < 4; k++) begin
      begin_cycle();
      ckpt_req = 1'b1;
      @(negedge clock);
      chk_ckpt($sformatf("ck_fill%0d", k), 2'(k), 1'b0);
    end
    begin_cycle();
    ckpt_req = 1'b1;
    @(negedge clock);
    chk_ckpt("ck_full_req", 2'd0, 1'b1);
    begin_cycle();
    ckpt_release = 1'b1;
    @(negedge clock);
    chk_ckpt("ck_full_ignored", 2'd0, 1'b1);
    begin_cycle();
    ckpt_release = 1'b1; ckpt_req = 1'b1;
    @(negedge clock);
    chk_ckpt("ck_rel_req", 2'd0, 1'b0);
    begin_cycle();
    ckpt_req = 1'b1;
    @(negedge clock);
    chk_ckpt("ck_wrap", 2'd1, 1'b0);
    begin_cycle();
    @(negedge clock);
    chk_ckpt("ck_refull", 2'd2, 1'b1);

    // Reset mid-operation drops every checkpoint and mapping
    begin_cycle();
    reset = 1'b1;
    begin_cycle();
    reset = 1'b0;
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd0);
    @(negedge clock);
    chk_rs("ck_reset_r1", 0, 1, Z);
    chk_ckpt("ck_reset", 2'd0, 1'b0);
`else
    // Without checkpoints a squash wipes the whole map
    begin_cycle();
    set_lane(0, 1'b1, 5'd1, 5'd4, 5'd0, 5'd0);
    ckpt_req = 1'b1;
    @(negedge clock);
    chk_ckpt("nock_req", 2'd0, 1'b1);

    begin_cycle();
    squash = 1'b1; ckpt_release = 1'b1;
    set_lane(0, 1'b1, 5'd2, 5'd6, 5'd1, 5'd0);
    @(negedge clock);
    chk_rs("nock_presquash_r1", 0, 1, ex(4,1'b1,1'b0));

    begin_cycle();
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd1, 5'd3);
    set_lane(1, 1'b0, 5'd0, 5'd0, 5'd2, 5'd0);
    @(negedge clock);
    chk_rs("nock_squash_r1", 0, 1, Z);
    chk_rs("nock_squash_r3", 0, 2, Z);
    chk_rs("nock_squash_r2", 1, 1, Z);
    chk_ckpt("nock_after_squash", 2'd0, 1'b1);

    begin_cycle();
    set_lane(0, 1'b1, 5'd3, 5'd13, 5'd0, 5'd0);
    begin_cycle();
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0);
    @(negedge clock);
    chk_rs("nock_remap_r3", 0, 1, ex(13,1'b1,1'b0));

    begin_cycle();
    reset = 1'b1;
    begin_cycle();
    reset = 1'b0;
    set_lane(0, 1'b0, 5'd0, 5'd0, 5'd3, 5'd0);
    @(negedge clock);
    chk_rs("nock_reset_r3", 0, 1, Z);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/map_table_nway.md
# map_table_nway

N-way superscalar register map table, a parametrised successor of the single-dispatch map table. It sits between dispatch and the reservation stations. Each cycle it renames up to DISPATCH_W instructions, with intra-bundle dependency bypass. It absorbs up to CDB_W completion broadcasts and RETIRE_W retirements, and it optionally keeps a circular buffer of branch checkpoints for single-cycle misprediction recovery.

## Interface
- NUM_ARCH_REGS, 32: architectural registers; index width RW = $clog2(NUM_ARCH_REGS).
- TAG_W, 5: ROB-index tag width.
- DISPATCH_W, 2: rename lanes per cycle.
- CDB_W, 2: completion broadcast channels.
- RETIRE_W, 2: retire channels.
- NUM_CKPT, 4: checkpoint slots, power of two (used only with the macro).
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- disp_valid  in  DISPATCH_W  lane i carries a dispatching instruction; lane 0 is oldest.
- disp_dest_idx / disp_dest_tag  in  DISPATCH_W*RW / DISPATCH_W*TAG_W  destination register and its ROB tag.
- disp_rs1_idx / disp_rs2_idx  in  DISPATCH_W*RW  source registers.
- rs1_tag / rs2_tag  out  DISPATCH_W*TAG_W  source mapping.
- rs1_valid / rs2_valid  out  DISPATCH_W  1 = mapped to ROB; 0 = value is in the regfile.
- rs1_ready / rs2_ready  out  DISPATCH_W  mapped tag has completed.
- cdb_valid / cdb_tag  in  CDB_W / CDB_W*TAG_W  completion broadcasts.
- retire_valid / retire_tag  in  RETIRE_W / RETIRE_W*TAG_W  retiring ROB entries.
- ckpt_req  in  1  snapshot request.
- ckpt_id  out  $clog2(NUM_CKPT)  slot allocated this cycle.
- ckpt_full  out  1  no free slot.
- ckpt_release  in  1  frees the oldest slot.
- squash / squash_id  in  1 / $clog2(NUM_CKPT)  restore a slot.

## Operation
- State per register: tag, valid, ready. Register 0 is never mapped: its writes are ignored and its reads always return valid=0.
- Rename read (combinational), lane j source r:
  - If an older lane i<j with disp_valid writes r, the youngest such lane supplies the output: tag, valid=1, ready=0.
  - Otherwise the stored entry is used. ready is forced to 1 if any cdb_valid/cdb_tag matches the stored valid tag in the same cycle.
- Dispatch write: entry[dest] <= {disp_dest_tag, valid=1, ready=0}. When lanes share a dest, the highest lane wins.
- CDB: every stored entry with valid=1 and a tag equal to an active cdb_tag sets ready=1. A dispatch write to the same register in the same cycle wins.
- Retire: every entry with valid=1 and a tag equal to an active retire_tag clears to valid=0, ready=0. A dispatch write to the same register in the same cycle wins.
- Priority: reset > squash > dispatch > retire > CDB.
- Checkpoints (macro on):
  - Slots form a circular FIFO with head/tail pointers and a count.
  - ckpt_req with !ckpt_full copies the post-update map of this cycle (all lanes' writes included) into slot tail. ckpt_id = tail, tail++.
  - A request while ckpt_full is ignored.
  - Live slots also receive the CDB-ready and retire-clear updates every cycle.
  - ckpt_release: head++, ignored when empty. Release and request may occur in the same cycle.
  - squash: the map is loaded from slot squash_id with that cycle's CDB/retire updates applied, and tail <= squash_id, which frees the slot and all younger slots. Dispatch and ckpt_req are ignored that cycle.

## Timing
- Rename read: 0 cycles, combinational. Table updates are visible the next cycle.
- Reset values: all entries valid=0, ready=0, tag=0; head=tail=count=0; ckpt_full=0; ckpt_id=0.
- Reset asserted mid-operation discards all checkpoints within one cycle.
- ckpt_full is registered from count and is 1 when count==NUM_CKPT. Pointers wrap modulo NUM_CKPT.

## Configuration
- MAP_TABLE_CKPT_EN defined: checkpoint storage and FIFO are built as described.
- MAP_TABLE_CKPT_EN undefined: no storage. squash clears every entry to valid=0 (full recovery from the regfile). ckpt_id=0, ckpt_full=1; ckpt_req and ckpt_release are ignored.

## Test plan
- Reset, then read r5 on both lanes -> valid=0, ready=0, tag=0.
- Lane0 dest r3 tag 7 and lane1 rs1=r3, same cycle -> lane1 rs1_tag=7, valid=1, ready=0. Next cycle r3 is stored with tag 7.
- r4 stored with tag 9; cdb tag 9 and a read of r4 in the same cycle -> ready=1. Retire tag 9 next cycle -> following read shows valid=0.
- Both lanes dest r6 (tags 2, 3) plus cdb tag 2 -> r6 = tag 3, ready=0.
- Macro on: map r1 to tag 4 and take ckpt_req (ckpt_id=0); map r1 to tag 5; cdb tag 4; squash id 0 -> r1 = tag 4, ready=1, count=0.
- Macro on: fill NUM_CKPT slots -> ckpt_full=1 and a further request is ignored. Release plus request in one cycle -> count unchanged, tail wraps to 0.
